// File: rtl/alu_issue_stage_if.sv
// rtl/alu_issue_stage_if.sv - ID-side op bus, ALU drive/return and EX/MEM result bus of alu_issue_stage (optional flags under ALU_FLAGS_EN)
interface alu_issue_stage_if #(
  parameter int DATA_W = 64,
  parameter int DEST_W = 5
);
  // op presented by ID
  logic              In_valid;
  logic              In_ready;
  logic [3:0]        Opcode;
  logic [DATA_W-1:0] Rs1_val;
  logic [DATA_W-1:0] Rs2_val;
  logic [5:0]        Imm;
  logic [DEST_W-1:0] Dest;
  // combinational ALU drive and return
  logic [DATA_W-1:0] Alu_A;
  logic [DATA_W-1:0] Alu_B;
  logic [5:0]        Alu_Shiftamt;
  logic [2:0]        Alu_Sel;
  logic [DATA_W-1:0] Alu_Output;
  // registered result towards MEM
  logic              Out_valid;
  logic              Out_ready;
  logic [DATA_W-1:0] Out_result;
  logic [DEST_W-1:0] Out_dest;
  logic              Out_illegal;
`ifdef ALU_FLAGS_EN
  logic              Out_zero;
  logic              Out_neg;
`endif

  modport master (
    output In_valid, Opcode, Rs1_val, Rs2_val, Imm, Dest, Alu_Output, Out_ready,
    input  In_ready, Alu_A, Alu_B, Alu_Shiftamt, Alu_Sel,
           Out_valid, Out_result, Out_dest, Out_illegal
`ifdef ALU_FLAGS_EN
    , input Out_zero, Out_neg
`endif
  );

  modport slave (
    input  In_valid, Opcode, Rs1_val, Rs2_val, Imm, Dest, Alu_Output, Out_ready,
    output In_ready, Alu_A, Alu_B, Alu_Shiftamt, Alu_Sel,
           Out_valid, Out_result, Out_dest, Out_illegal
`ifdef ALU_FLAGS_EN
    , output Out_zero, Out_neg
`endif
  );
endinterface

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - 2-deep issue/result pipeline driving a 64-bit 8-op ALU (optional flags under ALU_FLAGS_EN)
module alu_issue_stage #(
  parameter int DATA_W = 64,
  parameter int DEST_W = 5
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Flush,
  alu_issue_stage_if.slave bus
);

  // Sel 7 makes the ALU return 0; used for NOP, illegal ops and idle
  localparam logic [2:0] SEL_ZERO  = 3'd7;
  localparam logic [2:0] SEL_SHIFT = 3'd6;

  // stage 1: issue register feeding the ALU
  logic              s1_valid;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  logic [5:0]        s1_shamt;
  logic [2:0]        s1_sel;
  logic [DEST_W-1:0] s1_dest;
  logic              s1_illegal;

  // stage 2: EX/MEM result register
  logic              out_valid;
  logic [DATA_W-1:0] out_result;
  logic [DEST_W-1:0] out_dest;
  logic              out_illegal;
`ifdef ALU_FLAGS_EN
  logic              out_zero;
  logic              out_neg;
`endif

  // decoded form of the op currently presented by ID
  logic [2:0]        d_sel;
  logic [5:0]        d_shamt;
  logic              d_illegal;

  logic              s2_adv;
  logic              accept;

  // s1 moves into s2 whenever s2 is empty or being drained this cycle
  assign s2_adv       = s1_valid & (~out_valid | bus.Out_ready);
  assign bus.In_ready = Reset_n & ~Flush & (~s1_valid | s2_adv);
  assign accept       = bus.In_valid & bus.In_ready;

  // ALU is fed only from registers so ID timing never reaches the ALU
  assign bus.Alu_A        = s1_a;
  assign bus.Alu_B        = s1_b;
  assign bus.Alu_Shiftamt = s1_shamt;
  assign bus.Alu_Sel      = s1_sel;

  assign bus.Out_valid    = out_valid;
  assign bus.Out_result   = out_result;
  assign bus.Out_dest     = out_dest;
  assign bus.Out_illegal  = out_illegal;
`ifdef ALU_FLAGS_EN
  assign bus.Out_zero     = out_zero;
  assign bus.Out_neg      = out_neg;
`endif

  // opcode -> ALU select / shift amount; non-shift ops keep shift amount at 0
  always_comb begin
    d_sel     = SEL_ZERO;
    d_shamt   = 6'd0;
    d_illegal = 1'b0;
    case (bus.Opcode)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5: d_sel = bus.Opcode[2:0];
      4'd6: begin
        d_sel   = SEL_SHIFT;
        d_shamt = bus.Rs2_val[5:0];
      end
      4'd7: begin
        d_sel   = SEL_SHIFT;
        d_shamt = bus.Imm;
      end
      4'd8:    d_sel = SEL_ZERO;
      default: d_illegal = 1'b1;
    endcase
  end

  // issue register: flush wins, data loads only on accept
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_shamt   <= '0;
      s1_sel     <= SEL_ZERO;
      s1_dest    <= '0;
      s1_illegal <= 1'b0;
    end else begin
      if (Flush)       s1_valid <= 1'b0;
      else if (accept) s1_valid <= 1'b1;
      else if (s2_adv) s1_valid <= 1'b0;
      if (accept) begin
        s1_a       <= bus.Rs1_val;
        s1_b       <= bus.Rs2_val;
        s1_shamt   <= d_shamt;
        s1_sel     <= d_sel;
        s1_dest    <= bus.Dest;
        s1_illegal <= d_illegal;
      end
    end
  end

  // result register: captures the ALU return when s1 advances, held while stalled
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_dest    <= '0;
      out_illegal <= 1'b0;
`ifdef ALU_FLAGS_EN
      out_zero    <= 1'b0;
      out_neg     <= 1'b0;
`endif
    end else begin
      if (Flush)              out_valid <= 1'b0;
      else if (s2_adv)        out_valid <= 1'b1;
      else if (bus.Out_ready) out_valid <= 1'b0;
      if (s2_adv && !Flush) begin
        out_result  <= bus.Alu_Output;
        out_dest    <= s1_dest;
        out_illegal <= s1_illegal;
`ifdef ALU_FLAGS_EN
        out_zero    <= (bus.Alu_Output == '0);
        out_neg     <= bus.Alu_Output[DATA_W-1];
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - randomized scoreboard bench for alu_issue_stage (flag checks under ALU_FLAGS_EN)
module tb_alu_issue_stage;

  localparam int DATA_W = 64;
  localparam int DEST_W = 5;

  logic Clk;
  logic Reset_n;
  logic Flush;

  int n_checks = 0;
  int n_errors = 0;

  alu_issue_stage_if #(.DATA_W(DATA_W), .DEST_W(DEST_W)) ifc ();

  alu_issue_stage #(.DATA_W(DATA_W), .DEST_W(DEST_W)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Flush   (Flush),
    .bus     (ifc.slave)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // the ALU the stage drives, described by select code
  function automatic logic [63:0] alu_model(input logic [2:0] sel, input logic [63:0] a,
                                            input logic [63:0] b, input logic [5:0] sh);
    case (sel)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a | b;
      3'd3: return ~(a ^ b);
      3'd4: return a & b;
      3'd5: return (a < b) ? 64'd1 : 64'd0;
      3'd6: return a << sh;
      default: return 64'd0;
    endcase
  endfunction

  always_comb ifc.Alu_Output = alu_model(ifc.Alu_Sel, ifc.Alu_A, ifc.Alu_B, ifc.Alu_Shiftamt);

  // architectural meaning of each EX opcode
  function automatic logic [63:0] op_result(input logic [3:0] op, input logic [63:0] rs1,
                                            input logic [63:0] rs2, input logic [5:0] imm);
    case (op)
      4'd0: return rs1 + rs2;
      4'd1: return rs1 - rs2;
      4'd2: return rs1 | rs2;
      4'd3: return ~(rs1 ^ rs2);
      4'd4: return rs1 & rs2;
      4'd5: return (rs1 < rs2) ? 64'd1 : 64'd0;
      4'd6: return rs1 << rs2[5:0];
      4'd7: return rs1 << imm;
      default: return 64'd0;
    endcase
  endfunction

  typedef struct {
    logic [63:0] res;
    logic [4:0]  dest;
    logic        illegal;
    bit          fresh;
  } exp_t;

  exp_t q[$];

  // ops in flight, oldest first; a just-accepted op is not yet visible on the output
  always @(negedge Clk) begin
    exp_t e;
    check("in_ready", ifc.In_ready,
          Reset_n && !Flush && (q.size() < 2 || ifc.Out_ready));
    check("out_valid", ifc.Out_valid, q.size() > 0 && !q[0].fresh);
    if (ifc.Out_valid && q.size() > 0 && !q[0].fresh) begin
      check("out_result", ifc.Out_result, q[0].res);
      check("out_dest", ifc.Out_dest, q[0].dest);
      check("out_illegal", ifc.Out_illegal, q[0].illegal);
`ifdef ALU_FLAGS_EN
      check("out_zero", ifc.Out_zero, q[0].res == 64'd0);
      check("out_neg", ifc.Out_neg, q[0].res[63]);
`endif
    end
    foreach (q[i]) q[i].fresh = 1'b0;
    if (!Reset_n || Flush) begin
      q.delete();
    end else begin
      if (ifc.Out_valid && ifc.Out_ready && q.size() > 0) void'(q.pop_front());
      if (ifc.In_valid && ifc.In_ready) begin
        e.res     = op_result(ifc.Opcode, ifc.Rs1_val, ifc.Rs2_val, ifc.Imm);
        e.dest    = ifc.Dest;
        e.illegal = ifc.Opcode > 4'd8;
        e.fresh   = 1'b1;
        q.push_back(e);
      end
    end
  end

  task automatic set_op(input logic [3:0] op, input logic [63:0] rs1, input logic [63:0] rs2,
                        input logic [5:0] imm, input logic [4:0] dest);
    ifc.Opcode  = op;
    ifc.Rs1_val = rs1;
    ifc.Rs2_val = rs2;
    ifc.Imm     = imm;
    ifc.Dest    = dest;
  endtask

  // present one op and hold it until accepted; returns 1 ns after the accepting edge
  task automatic send(input logic [3:0] op, input logic [63:0] rs1, input logic [63:0] rs2,
                      input logic [5:0] imm, input logic [4:0] dest);
    bit ok;
    ok = 1'b0;
    set_op(op, rs1, rs2, imm, dest);
    ifc.In_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      if (ifc.In_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("send_timeout", 64'd0, 64'd1);
    @(posedge Clk);
    #1;
    ifc.In_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset_n       = 1'b0;
    Flush         = 1'b0;
    ifc.In_valid  = 1'b0;
    ifc.Out_ready = 1'b1;
    set_op(4'd0, 64'd0, 64'd0, 6'd0, 5'd0);

    // reset held for two edges
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("rst_out_valid", ifc.Out_valid, 64'd0);
    check("rst_in_ready", ifc.In_ready, 64'd0);
    check("rst_alu_sel", ifc.Alu_Sel, 64'd7);
    check("rst_out_result", ifc.Out_result, 64'd0);
    check("rst_alu_output", ifc.Alu_Output, 64'd0);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    idle(1);

    // ADD: result two edges after accept
    send(4'd0, 64'd5, 64'd7, 6'd0, 5'd3);
    @(negedge Clk);
    check("add_not_early", ifc.Out_valid, 64'd0);
    @(negedge Clk);
    check("add_valid", ifc.Out_valid, 64'd1);
    check("add_result", ifc.Out_result, 64'd12);
    check("add_dest", ifc.Out_dest, 64'd3);
    idle(2);

    // SLLI by the maximum immediate
    send(4'd7, 64'd1, 64'hFFFF, 6'd63, 5'd9);
    @(negedge Clk);
    check("slli_shamt", ifc.Alu_Shiftamt, 64'd63);
    check("slli_sel", ifc.Alu_Sel, 64'd6);
    @(negedge Clk);
    check("slli_result", ifc.Out_result, 64'h8000_0000_0000_0000);
    idle(2);

    // illegal opcode produces a flagged zero result
    send(4'd12, 64'h1234, 64'h5678, 6'd5, 5'd17);
    @(negedge Clk);
    check("illegal_sel", ifc.Alu_Sel, 64'd7);
    @(negedge Clk);
    check("illegal_flag", ifc.Out_illegal, 64'd1);
    check("illegal_result", ifc.Out_result, 64'd0);
`ifdef ALU_FLAGS_EN
    check("illegal_zero", ifc.Out_zero, 64'd1);
`endif
    idle(2);

    // backpressure: four back-to-back ops with MEM stalled for three edges
    ifc.Out_ready = 1'b0;
    fork
      begin
        send(4'd0, 64'd1, 64'd1, 6'd0, 5'd1);
        send(4'd1, 64'd10, 64'd3, 6'd0, 5'd2);
        send(4'd2, 64'hF0, 64'h0F, 6'd0, 5'd3);
        send(4'd6, 64'd3, 64'd4, 6'd0, 5'd4);
      end
      begin
        repeat (3) @(negedge Clk);
        check("bp_in_ready_low", ifc.In_ready, 64'd0);
        @(posedge Clk);
        #1;
        ifc.Out_ready = 1'b1;
      end
    join
    idle(4);
    check("bp_drained", q.size(), 64'd0);

    // flush with both stages full and a new op waiting
    ifc.Out_ready = 1'b0;
    send(4'd4, 64'hFF00, 64'h0FF0, 6'd0, 5'd5);
    send(4'd3, 64'd0, 64'd0, 6'd0, 5'd6);
    set_op(4'd0, 64'd100, 64'd200, 6'd0, 5'd7);
    ifc.In_valid = 1'b1;
    Flush        = 1'b1;
    @(negedge Clk);
    check("flush_in_ready", ifc.In_ready, 64'd0);
    @(posedge Clk);
    #1;
    Flush        = 1'b0;
    ifc.In_valid = 1'b0;
    @(negedge Clk);
    check("flush_out_valid", ifc.Out_valid, 64'd0);
    check("flush_s1_empty", ifc.In_ready, 64'd1);
    @(posedge Clk);
    #1;
    ifc.Out_ready = 1'b1;
    idle(3);

    // randomized traffic with occasional flush and reset
    for (int c = 0; c < 600; c++) begin
      ifc.In_valid  = ($urandom_range(0, 9) < 7);
      ifc.Out_ready = ($urandom_range(0, 3) != 0);
      Flush         = ($urandom_range(0, 39) == 0);
      Reset_n       = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 3) == 0)
        set_op(4'($urandom_range(0, 15)), 64'($urandom_range(0, 20)),
               64'($urandom_range(0, 20)), 6'($urandom), 5'($urandom));
      else
        set_op(4'($urandom_range(0, 15)), {$urandom, $urandom}, {$urandom, $urandom},
               6'($urandom), 5'($urandom));
      @(posedge Clk);
      #1;
    end

    // drain
    ifc.In_valid  = 1'b0;
    ifc.Out_ready = 1'b1;
    Flush         = 1'b0;
    Reset_n       = 1'b1;
    idle(5);
    check("final_drained", q.size(), 64'd0);
    check("final_out_valid", ifc.Out_valid, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
